// File: rtl/tx_arp.sv
// ARP frame transmitter: emits a 28-byte ARP body plus zero padding on an
// 8-bit AXI-Stream, or passes the upstream stream straight through when idle.
module tx_arp #(
    parameter int ARP_PAD_BYTES = 18
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_reset,
    input  logic        arp_enable,
    input  logic        arp_start,
    input  logic [15:0] arp_opcode,
    input  logic [47:0] arp_srcMac,
    input  logic [31:0] arp_srcIP,
    input  logic [47:0] arp_destMac,
    input  logic [31:0] arp_destIP,
    output logic        arp_busy,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
);
    localparam int         FRAME_LEN = 28 + ARP_PAD_BYTES;
    localparam logic [5:0] LAST_IDX  = 6'(FRAME_LEN - 1);
    localparam logic [5:0] BODY_LAST = 6'd27;

    typedef enum logic [1:0] {IDLE, BODY, PAD} state_t;

    state_t      state_q;
    logic [5:0]  idx_q;
    logic [15:0] opcode_q;
    logic [47:0] srcMac_q;
    logic [31:0] srcIP_q;
    logic [47:0] destMac_q;
    logic [31:0] destIP_q;
    logic        m_tvalid_q;
    logic        m_tlast_q;
    logic        m_tuser_q;
    logic [7:0]  m_tdata_q;

    logic [5:0]   idx_d;
    logic [7:0]   tdata_d;
    logic [223:0] body;
    logic         sel;

    function automatic logic [7:0] body_byte(input logic [223:0] b, input logic [5:0] i);
        logic [223:0] sh;
        sh = b << {i, 3'b000};
        return sh[223:216];
    endfunction

    assign body  = {16'h0001, 16'h0800, 8'h06, 8'h04,
                    opcode_q, srcMac_q, srcIP_q, destMac_q, destIP_q};
    assign idx_d = idx_q + 6'd1;

    // Byte that becomes visible after the current beat is accepted.
    always_comb begin
        tdata_d = 8'h00;
        if (idx_d <= BODY_LAST)
            tdata_d = body_byte(body, idx_d);
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            opcode_q   <= '0;
            srcMac_q   <= '0;
            srcIP_q    <= '0;
            destMac_q  <= '0;
            destIP_q   <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            m_tdata_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arp_start && arp_enable) begin
                        opcode_q   <= arp_opcode;
                        srcMac_q   <= arp_srcMac;
                        srcIP_q    <= arp_srcIP;
                        destMac_q  <= arp_destMac;
                        destIP_q   <= arp_destIP;
                        idx_q      <= '0;
                        state_q    <= BODY;
                        m_tvalid_q <= 1'b1;
                        m_tuser_q  <= 1'b1;
                        m_tlast_q  <= 1'b0;
                        // Byte 0 is the high byte of hardware type 0x0001.
                        m_tdata_q  <= 8'h00;
                    end
                end
                default: begin
                    if (m_axis_tready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q    <= IDLE;
                            idx_q      <= '0;
                            m_tvalid_q <= 1'b0;
                            m_tlast_q  <= 1'b0;
                            m_tuser_q  <= 1'b0;
                            m_tdata_q  <= 8'h00;
                        end else begin
                            idx_q     <= idx_d;
                            m_tdata_q <= tdata_d;
                            m_tuser_q <= 1'b0;
                            m_tlast_q <= (idx_d == LAST_IDX);
                            state_q   <= (idx_d > BODY_LAST) ? PAD : BODY;
                        end
                    end
                end
            endcase
        end
    end

    assign arp_busy = (state_q != IDLE);
    assign sel      = arp_enable | arp_busy;

    assign m_axis_tvalid = sel ? m_tvalid_q : s_axis_tvalid;
    assign m_axis_tdata  = sel ? m_tdata_q  : s_axis_tdata;
    assign m_axis_tlast  = sel ? m_tlast_q  : s_axis_tlast;
    assign m_axis_tuser  = sel ? m_tuser_q  : s_axis_tuser;
    assign s_axis_tready = sel ? 1'b0       : m_axis_tready;
endmodule

// File: tb/tb_tx_arp.sv
// Bench for tx_arp: a golden table for the reference request frame, directed
// corner sequences and a random phase, all checked against a frame-level model.
module tb_tx_arp;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, start;
    logic [15:0] op;
    logic [47:0] smac, dmac;
    logic [31:0] sip, dip;
    logic        busy;
    logic [7:0]  s_tdata, m_tdata;
    logic        s_tlast, s_tuser, s_tvalid, s_tready;
    logic        m_tlast, m_tuser, m_tvalid, m_tready;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model: busy flag, position in frame, captured frame bytes.
    bit         mb;
    int         mpos;
    logic [7:0] mframe [46];

    tx_arp dut (
        .s_axis_aclk(clk), .s_axis_reset(rst), .arp_enable(en), .arp_start(start),
        .arp_opcode(op), .arp_srcMac(smac), .arp_srcIP(sip), .arp_destMac(dmac),
        .arp_destIP(dip), .arp_busy(busy),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_frame();
        logic [7:0] q[$];
        q = {8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04};
        for (int k = 1; k >= 0; k--) q.push_back(8'(op >> (8 * k)));
        for (int k = 5; k >= 0; k--) q.push_back(8'(smac >> (8 * k)));
        for (int k = 3; k >= 0; k--) q.push_back(8'(sip >> (8 * k)));
        for (int k = 5; k >= 0; k--) q.push_back(8'(dmac >> (8 * k)));
        for (int k = 3; k >= 0; k--) q.push_back(8'(dip >> (8 * k)));
        while (q.size() < 46) q.push_back(8'h00);
        for (int k = 0; k < 46; k++) mframe[k] = q[k];
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic tick();
        bit sel;
        @(negedge clk);
        sel = en | mb;
        chk("busy", busy, mb);
        if (sel) begin
            chk("m_tvalid", m_tvalid, mb);
            chk("s_tready", s_tready, 0);
            chk("m_tlast", m_tlast, mb && mpos == 45);
            chk("m_tuser", m_tuser, mb && mpos == 0);
            if (mb) chk("m_tdata", m_tdata, mframe[mpos]);
        end else begin
            chk("pt_tvalid", m_tvalid, s_tvalid);
            chk("pt_tdata", m_tdata, s_tdata);
            chk("pt_tlast", m_tlast, s_tlast);
            chk("pt_tuser", m_tuser, s_tuser);
            chk("pt_tready", s_tready, m_tready);
        end
        @(posedge clk);
        if (rst) begin
            mb = 0; mpos = 0;
        end else if (mb) begin
            if (m_tready) begin
                mpos++;
                if (mpos == 46) begin mb = 0; mpos = 0; end
            end
        end else if (start && en) begin
            build_frame();
            mb = 1; mpos = 0;
        end
        #1;
    endtask

    task automatic run_to(input int pos, input int max);
        int g = 0;
        while (!(mb && mpos == pos)) begin
            if (g >= max) begin chk("run_to_timeout", 0, 1); break; end
            tick();
            g++;
        end
    endtask

    task automatic ref_fields();
        op = 16'h0001; smac = 48'h000A35010203; sip = 32'hC0A8010A;
        dmac = 48'h0; dip = 32'hC0A80114;
    endtask

    task automatic rand_fields();
        op = 16'($urandom); smac = {16'($urandom), $urandom}; sip = $urandom;
        dmac = {16'($urandom), $urandom}; dip = $urandom;
    endtask

    task automatic rand_s();
        s_tdata = 8'($urandom); s_tvalid = 1'($urandom); s_tlast = 1'($urandom);
        s_tuser = 1'($urandom);
    endtask

    typedef struct {
        logic       start, en, rdy;
        logic       exp_v;
        logic [7:0] exp_d;
        logic       exp_u, exp_l, exp_b;
    } vec_t;

    vec_t       tbl [48];
    logic [7:0] body28 [28] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                                8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03, 8'hC0, 8'hA8,
                                8'h01, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'hC0, 8'hA8, 8'h01, 8'h14};

    initial begin
        int cnt;
        mb = 0; mpos = 0;
        rst = 1; en = 1; start = 0; m_tready = 1;
        s_tdata = 0; s_tvalid = 0; s_tlast = 0; s_tuser = 0;
        ref_fields();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tuser", m_tuser, 0);
        chk("rst_s_tready", s_tready, 0);
        tick();
        rst = 0;
        tick();

        // Golden request frame; fields scrambled after the start cycle must not leak in.
        for (int i = 0; i < 48; i++) begin
            tbl[i].start = (i == 0);
            tbl[i].en    = 1'b1;
            tbl[i].rdy   = 1'b1;
            tbl[i].exp_v = (i >= 1 && i <= 46);
            tbl[i].exp_d = (i >= 1 && i <= 28) ? body28[i-1] : 8'h00;
            tbl[i].exp_u = (i == 1);
            tbl[i].exp_l = (i == 46);
            tbl[i].exp_b = (i >= 1 && i <= 46);
        end
        for (int i = 0; i < 48; i++) begin
            start = tbl[i].start; en = tbl[i].en; m_tready = tbl[i].rdy;
            if (i > 0) rand_fields();
            #2;
            chk("tbl_valid", m_tvalid, tbl[i].exp_v);
            chk("tbl_busy", busy, tbl[i].exp_b);
            chk("tbl_user", m_tuser, tbl[i].exp_u);
            chk("tbl_last", m_tlast, tbl[i].exp_l);
            if (tbl[i].exp_v) chk("tbl_data", m_tdata, tbl[i].exp_d);
            tick();
        end

        // Backpressure: tready toggles, 46 beats take 92 busy cycles.
        ref_fields(); start = 1; m_tready = 0; tick(); start = 0;
        cnt = 0;
        for (int c = 0; c < 200 && mb; c++) begin
            m_tready = c[0];
            if (busy) cnt++;
            tick();
        end
        chk("bp_cycles", cnt, 92);
        m_tready = 1; tick();

        // Starts during a frame (beat 10, final beat 45) and in pass-through are ignored.
        rand_fields(); start = 1; tick(); start = 0;
        run_to(10, 60); start = 1; tick(); start = 0;
        run_to(45, 60); start = 1; tick(); start = 0;
        #1 chk("no_restart", busy, 0);
        repeat (4) tick();
        en = 0; start = 1; rand_s(); tick(); start = 0;
        repeat (3) begin rand_s(); tick(); end
        chk("no_pt_frame", busy, 0);

        // Pass-through of a 60-byte upstream frame.
        for (int k = 0; k < 60; k++) begin
            s_tdata = 8'($urandom); s_tvalid = 1; s_tuser = (k == 0); s_tlast = (k == 59);
            m_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        m_tready = 1;

        // Enable drop at beat 20: frame completes, then pass-through resumes.
        en = 1; rand_fields(); start = 1; tick(); start = 0;
        run_to(20, 60); en = 0;
        for (int c = 0; c < 60 && mb; c++) begin rand_s(); tick(); end
        repeat (4) begin rand_s(); tick(); end

        // Reset at beat 15 aborts; a fresh start then yields a full frame.
        en = 1; rand_fields(); start = 1; tick(); start = 0;
        run_to(15, 60); rst = 1; tick(); rst = 0;
        chk("abort_tvalid", m_tvalid, 0);
        chk("abort_busy", busy, 0);
        rand_fields(); start = 1; tick(); start = 0;
        repeat (50) tick();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 7) != 0);
            start = ($urandom_range(0, 9) == 0);
            m_tready = ($urandom_range(0, 3) != 0);
            rand_fields(); rand_s();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
